// File: rtl/rns_pkg.sv
// Shared definitions for the RNS-to-binary sequencer: default widths, FSM states, counter sizing.
// Moduli set {2^n-1, 2^n+1, 2^2n+1, 2^(2n+p)}; defaults n=20, p=7.
package rns_pkg;

  localparam int RNS_N = 20;
  localparam int RNS_P = 7;

  localparam int W_R1 = RNS_N;
  localparam int W_R2 = RNS_N + 1;
  localparam int W_R3 = 2*RNS_N + 1;
  localparam int W_R4 = 2*RNS_N + RNS_P;
  localparam int W_X  = 6*RNS_N + RNS_P + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  // Wide enough to hold 0..wait_cyc.
  function automatic int cnt_width(input int wait_cyc);
    return (wait_cyc < 1) ? 1 : $clog2(wait_cyc + 1);
  endfunction

endpackage

// File: rtl/rns_conv.sv
// Combinational RNS-to-binary converter for {2^n-1, 2^n+1, 2^2n+1, 2^(2n+p)}.
// Latency: none (timed as a multicycle path by the caller); no flow control.
module rns_conv #(
  parameter int n = 20,
  parameter int p = 7
) (
  input  logic [n-1:0]       r1,
  input  logic [n:0]         r2,
  input  logic [2*n:0]       r3,
  input  logic [2*n+p-1:0]   r4,
  output logic [6*n+p:0]     x
);

  localparam int K  = 2*n + p;
  localparam int WW = 6*n + p + 2;

  // Modular inverses of 2^K are plain powers of two: 2 has order n, 2n, 4n in the three odd moduli.
  localparam int S1 = (n   - (K % n))     % n;
  localparam int S2 = (2*n - (K % (2*n))) % (2*n);
  localparam int S3 = (4*n - (K % (4*n))) % (4*n);

  localparam logic [WW-1:0] ONE = WW'(1);
  localparam logic [WW-1:0] M1  = (ONE << n) - ONE;
  localparam logic [WW-1:0] M2  = (ONE << n) + ONE;
  localparam logic [WW-1:0] M3  = (ONE << (2*n)) + ONE;
  localparam logic [WW-1:0] M12 = (ONE << (2*n)) - ONE;

  logic [WW-1:0] a1, a2, a3, a4;
  logic [WW-1:0] y1, y2, y3;
  logic [WW-1:0] t12, y12, t3, y;

  always_comb begin
    a1 = WW'(r1) % M1;
    a2 = WW'(r2) % M2;
    a3 = WW'(r3) % M3;
    a4 = WW'(r4);

    // Residues of Y = (X - r4) / 2^K over the three odd moduli.
    y1 = (((a1 + M1 - (a4 % M1)) % M1) << S1) % M1;
    y2 = (((a2 + M2 - (a4 % M2)) % M2) << S2) % M2;
    y3 = (((a3 + M3 - (a4 % M3)) % M3) << S3) % M3;

    // {2^n-1, 2^n+1}: inverse of (2^n+1) mod (2^n-1) is 2^(n-1).
    t12 = (((y1 + M1 - (y2 % M1)) % M1) << (n-1)) % M1;
    y12 = y2 + M2 * t12;

    // Extend with 2^2n+1: inverse of (2^2n-1) mod (2^2n+1) is 2^(2n-1).
    t3 = (((y3 + M3 - (y12 % M3)) % M3) << (2*n-1)) % M3;
    y  = y12 + M12 * t3;

    x = (6*n+p+1)'(a4 + (y << K));
  end

endmodule

// File: rtl/rns_conv_ctrl.sv
// Sequencer around rns_conv: registers one residue set, waits WAIT_CYC cycles, registers X. Option: RNS_RANGE_CHECK_EN.
// Latency: accept at edge E0 -> out_valid after edge E0+WAIT_CYC; one result per WAIT_CYC+1 cycles.
// Backpressure: out_valid holds until out_ready; in_ready low while busy, equals out_ready while a result waits.
module rns_conv_ctrl
  import rns_pkg::*;
#(
  parameter int n        = RNS_N,
  parameter int p        = RNS_P,
  parameter int WAIT_CYC = 4,
  parameter int TAG_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [n-1:0]         in_r1,
  input  logic [n:0]           in_r2,
  input  logic [2*n:0]         in_r3,
  input  logic [2*n+p-1:0]     in_r4,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [6*n+p:0]       out_x,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 out_err
);

  localparam int CW = cnt_width(WAIT_CYC);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            load, capture;

  logic [n-1:0]     r1_q;
  logic [n:0]       r2_q;
  logic [2*n:0]     r3_q;
  logic [2*n+p-1:0] r4_q;
  logic [TAG_W-1:0] tag_q;
  logic [6*n+p:0]   conv_x;

  // Converter sees only the residue registers so its inputs stay put for the whole wait.
  rns_conv #(
    .n (n),
    .p (p)
  ) u_conv (
    .r1 (r1_q),
    .r2 (r2_q),
    .r3 (r3_q),
    .r4 (r4_q),
    .x  (conv_x)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      r3_q    <= '0;
      r4_q    <= '0;
      tag_q   <= '0;
      out_x   <= '0;
      out_tag <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (load) begin
        r1_q  <= in_r1;
        r2_q  <= in_r2;
        r3_q  <= in_r3;
        r4_q  <= in_r4;
        tag_q <= in_tag;
      end
      if (capture) begin
        out_x   <= conv_x;
        out_tag <= tag_q;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    in_ready  = 1'b0;
    load      = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load      = 1'b1;
          cnt_nxt   = CW'(WAIT_CYC - 1);
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CW'(1);
        end else begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        // Handing off the result frees the residue registers in the same cycle.
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            load      = 1'b1;
            cnt_nxt   = CW'(WAIT_CYC - 1);
            state_nxt = WAIT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign out_valid = (state == DONE);

`ifdef RNS_RANGE_CHECK_EN
  logic err_in, err_q, out_err_q;

  // Non-canonical residues: r1 == 2^n-1, r2 > 2^n, r3 > 2^2n.
  assign err_in = (in_r1 == {n{1'b1}})
                | (in_r2[n]   & (|in_r2[n-1:0]))
                | (in_r3[2*n] & (|in_r3[2*n-1:0]));

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q     <= 1'b0;
      out_err_q <= 1'b0;
    end else begin
      if (load)    err_q     <= err_in;
      if (capture) out_err_q <= err_q;
    end
  end

  assign out_err = out_err_q;
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_rns_conv_ctrl.sv
// Directed bench for rns_conv_ctrl with n=20, p=7, WAIT_CYC=4, TAG_W=4.
module tb_rns_conv_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [19:0]  in_r1;
  logic [20:0]  in_r2;
  logic [40:0]  in_r3;
  logic [46:0]  in_r4;
  logic [3:0]   in_tag;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_x;
  logic [3:0]   out_tag;
  logic         out_err;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] M1 = (128'd1 << 20) - 128'd1;
  localparam logic [127:0] M2 = (128'd1 << 20) + 128'd1;
  localparam logic [127:0] M3 = (128'd1 << 40) + 128'd1;
  localparam logic [127:0] MM = ((128'd1 << 80) - 128'd1) << 47;

  rns_conv_ctrl #(.n(20), .p(7), .WAIT_CYC(4), .TAG_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_r1     (in_r1),
    .in_r2     (in_r2),
    .in_r3     (in_r3),
    .in_r4     (in_r4),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_tag   (out_tag),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [127:0] a1, input logic [127:0] a2, input logic [127:0] a3,
                       input logic [127:0] a4, input logic [3:0] t);
    in_r1  = a1[19:0];
    in_r2  = a2[20:0];
    in_r3  = a3[40:0];
    in_r4  = a4[46:0];
    in_tag = t;
  endtask

  task automatic drive_x(input logic [127:0] xv, input logic [3:0] t);
    drive(xv % M1, xv % M2, xv % M3, xv, t);
  endtask

  // Offers the driven set, then waits for and consumes its result (out_ready assumed high).
  task automatic run_one(output logic [127:0] xo, output logic [3:0] to, output logic eo, output int lat);
    int w;
    w = 0;
    in_valid = 1'b1;
    while (!in_ready && w < 20) begin
      step();
      w++;
    end
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    xo = out_x;
    to = out_tag;
    eo = out_err;
    step();
  endtask

  logic [127:0] rx, hx;
  logic [3:0]   rt, ht;
  logic         re;
  int           lat, w, seen, stable;
  int           idx, got, last_cyc;
  logic         acc, ovh;
  logic [2:0]   exp_err;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive(128'd0, 128'd0, 128'd0, 128'd0, 4'd0);
    step(); step(); step();
    rst = 1'b0;

    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_x",     out_x,           128'd0);
    check("rst_out_tag",   128'(out_tag),   128'd0);
    check("rst_out_err",   128'(out_err),   128'd0);
    check("rst_in_ready",  128'(in_ready),  128'd1);

    // All-zero residues.
    drive(128'd0, 128'd0, 128'd0, 128'd0, 4'd3);
    run_one(rx, rt, re, lat);
    check("zero_lat", 128'(lat), 128'd4);
    check("zero_x",   rx,        128'd0);
    check("zero_tag", 128'(rt),  128'd3);
    check("zero_err", 128'(re),  128'd0);

    // X = 5.
    drive(128'd5, 128'd5, 128'd5, 128'd5, 4'd4);
    run_one(rx, rt, re, lat);
    check("five_x",   rx,       128'd5);
    check("five_tag", 128'(rt), 128'd4);

    // X = 2^47: 2^47 mod (2^20-1) = 2^7, mod (2^20+1) = 2^7, mod (2^40+1) = 2^40-127.
    drive(128'd128, 128'd128, (128'd1 << 40) - 128'd127, 128'd0, 4'd6);
    run_one(rx, rt, re, lat);
    check("pow47_x", rx, 128'd1 << 47);

    // Random X below the dynamic range.
    for (int i = 0; i < 1000; i++) begin
      hx = {$urandom(), $urandom(), $urandom(), $urandom()};
      hx = hx % MM;
      drive_x(hx, 4'(i));
      run_one(rx, rt, re, lat);
      check("rand_x", rx, hx);
    end

    // Backpressure: result held while out_ready is low, no second accept.
    out_ready = 1'b0;
    drive_x(128'h1234_5678_9abc, 4'd1);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 20) begin
      step();
      w++;
    end
    check("bp_valid", 128'(out_valid), 128'd1);
    hx = out_x;
    ht = out_tag;
    check("bp_x",   hx,       128'h1234_5678_9abc);
    check("bp_tag", 128'(ht), 128'd1);
    drive_x(128'd777, 4'd2);
    in_valid = 1'b1;
    stable = 1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (in_ready) seen++;
      step();
      if (out_x !== hx || out_tag !== ht || out_valid !== 1'b1) stable = 0;
    end
    check("bp_hold",      128'(stable), 128'd1);
    check("bp_no_accept", 128'(seen),   128'd0);
    out_ready = 1'b1;
    #1;
    check("bp_rdy_follows", 128'(in_ready), 128'd1);
    step();
    in_valid = 1'b0;
    check("bp_valid_drop", 128'(out_valid), 128'd0);
    check("bp_busy",       128'(in_ready),  128'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check("bp_lat", 128'(lat),     128'd4);
    check("bp_x2",  out_x,         128'd777);
    check("bp_tag2", 128'(out_tag), 128'd2);
    step();

    // Back-to-back stream of 8 sets.
    idx = 0;
    got = 0;
    last_cyc = 0;
    drive_x(128'd7, 4'd0);
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
      acc = in_valid & in_ready;
      ovh = out_valid & out_ready;
      if (ovh) begin
        check("strm_tag", 128'(out_tag), 128'(got));
        check("strm_x",   out_x,         128'(got * 1000 + 7));
        if (got > 0) check("strm_gap", 128'(cyc - last_cyc), 128'd5);
        last_cyc = cyc;
        got++;
      end
      step();
      if (acc) begin
        idx++;
        if (idx < 8) drive_x(128'(idx * 1000 + 7), 4'(idx));
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("strm_count", 128'(got), 128'd8);
    w = 0;
    while (out_valid && w < 10) begin
      step();
      w++;
    end

    // Reset while waiting (cnt == 2) discards the transaction.
    drive_x(128'd99, 4'd5);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("wrst_valid", 128'(out_valid), 128'd0);
    check("wrst_ready", 128'(in_ready),  128'd1);
    check("wrst_x",     out_x,           128'd0);
    check("wrst_tag",   128'(out_tag),   128'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) seen++;
    end
    check("wrst_no_stale", 128'(seen), 128'd0);
    drive_x(128'd5, 4'd9);
    run_one(rx, rt, re, lat);
    check("wrst_fresh_lat", 128'(lat), 128'd4);
    check("wrst_fresh_x",   rx,        128'd5);
    check("wrst_fresh_tag", 128'(rt),  128'd9);

    // Range check cases: r1 = 2^20-1, r2 = 2^20+1, r3 = 2^40.
`ifdef RNS_RANGE_CHECK_EN
    exp_err = 3'b011;
`else
    exp_err = 3'b000;
`endif
    drive(M1, 128'd0, 128'd0, 128'd0, 4'd10);
    run_one(rx, rt, re, lat);
    check("err_r1", 128'(re), 128'(exp_err[0]));
    drive(128'd0, M2, 128'd0, 128'd0, 4'd11);
    run_one(rx, rt, re, lat);
    check("err_r2", 128'(re), 128'(exp_err[1]));
    drive(128'd0, 128'd0, 128'd1 << 40, 128'd0, 4'd12);
    run_one(rx, rt, re, lat);
    check("err_r3", 128'(re), 128'(exp_err[2]));
    check("err_r3_tag", 128'(rt), 128'd12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
